dht11_uart_reporter: RTL and testbench
======================================

Name: dht11_uart_reporter

Overview:
Downstream consumer of the DHT11 controller. On each completed measurement it captures humidity and temperature, converts both to 3-digit decimal ASCII by sequential double-dabble, and streams a text frame byte by byte into the existing UART transmitter. The UART transmitter interface is tx_start / tx_data / tx_busy / tx_done.

Parameters:
SEND_ERR, 1, 1: an invalid measurement emits an "ERR" frame; 0: an invalid measurement is silently discarded.
EOL_CRLF, 1, 1: frame ends with 0x0D 0x0A; 0: frame ends with 0x0A only.

Ports:
clk  input  1  system clock.
rst  input  1  asynchronous, active-low reset.
dht11_done  input  1  one-cycle pulse; measurement finished.
dht11_valid  input  1  checksum OK; sampled together with dht11_done.
rh_data  input  8  humidity integer byte; sampled on dht11_done.
t_data  input  8  temperature integer byte; sampled on dht11_done.
tx_busy  input  1  UART transmitter busy.
tx_done  input  1  one-cycle pulse; UART finished the current byte.
tx_start  output  1  one-cycle request to send tx_data.
tx_data  output  8  byte to send; held stable from tx_start until tx_done.
busy  output  1  high whenever state is not IDLE.
drop  output  1  one-cycle pulse when dht11_done arrives while busy.

Behaviour:
- Reset (rst=0, asynchronous): state IDLE. tx_start=0, tx_data=8'h00, busy=0, drop=0. Captured registers, BCD registers and byte index all cleared.
- Reset asserted mid-frame aborts immediately. No further tx_start is issued. A byte already handed to the UART is not recalled.
- IDLE, dht11_done=1: latch rh_data, t_data and dht11_valid.
  - valid=1 -> CONV.
  - valid=0 and SEND_ERR=1 -> LOAD_ERR.
  - valid=0 and SEND_ERR=0 -> stay in IDLE.
- CONV: double-dabble on both bytes in parallel, exactly 8 cycles.
  - Shift/add-3 rule: any nibble >=5 gets +3 before each shift.
  - Result per value: 3 BCD digits, 12 bits, range 000..255.
  - Then -> SEND with byte index 0.
- Valid frame byte sequence: 'H' ':' h2 h1 h0 ' ' 'T' ':' t2 t1 t0, then EOL.
  - Leading zeros are kept (e.g. 7 -> "007").
  - Digits are sent as 0x30+digit.
  - Length: 13 bytes with EOL_CRLF=1, 12 bytes otherwise.
- ERR frame: 'E' 'R' 'R', then EOL. Length 5 or 4 bytes. LOAD_ERR lasts 1 cycle, then -> SEND.
- SEND: while tx_busy=1, wait. When tx_busy=0: drive tx_data = byte[index], pulse tx_start for exactly 1 cycle, -> WAIT.
- WAIT: tx_start=0, tx_data held.
  - On tx_done: if the last byte was just sent -> IDLE, else index+1 -> SEND.
  - tx_done outside WAIT is ignored.
- Latency: with dht11_done sampled at edge N and tx_busy=0, the first tx_start is high in the cycle after edge N+9.
- dht11_done outside IDLE: the measurement is discarded and drop pulses for 1 cycle. The frame in flight is unaffected.
- dht11_done on the same edge the FSM returns to IDLE counts as busy: it is dropped.
- No timeout: if tx_done never arrives, the block stays in WAIT until reset.

Decomposition:
- Shared package dht11_pkg holds:
  - the FSM state enum: IDLE, CONV, LOAD_ERR, SEND, WAIT;
  - ASCII constants: CH_H, CH_T, CH_COLON, CH_SPACE, CH_E, CH_R, CH_CR, CH_LF, ASCII_0;
  - frame-length constants: FRAME_LEN_OK=13, FRAME_LEN_ERR=5.
- One sub-module, bin2bcd_seq: 8-bit sequential double-dabble with start/done handshake.
  - Instantiated twice (rh and t), started on the same cycle.
- Byte selection is a combinational mux inside the top block.

Test Plan:
1. rh=45, t=23, valid=1, tx_busy=0, UART model returns tx_done 3 cycles after each tx_start -> bytes 48 3A 30 34 35 20 54 3A 30 32 33 0D 0A, 13 tx_start pulses, busy falls after the last tx_done.
2. rh=255, t=0 -> digits "255" and "000"; check double-dabble at both range ends. With EOL_CRLF=0 -> 12 bytes, ending 0x0A.
3. valid=0, SEND_ERR=1 -> 45 52 52 0D 0A. Repeat with SEND_ERR=0 -> no tx_start, busy stays 0.
4. Second dht11_done during byte 5 -> drop pulses once; the first frame completes unchanged; no second frame follows.
5. tx_busy held high for 20 cycles before byte 0 -> tx_start withheld until tx_busy=0; tx_data stable from tx_start through tx_done.
6. rst pulled low in WAIT at byte 7 -> all outputs 0 immediately, state IDLE. After release, a new dht11_done with rh=12, t=34 sends a full "H:012 T:034" frame.

Source files
------------

// File: rtl/dht11_pkg.sv
// rtl/dht11_pkg.sv - shared FSM states, ASCII codes and helpers for the DHT11 UART reporter
package dht11_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CONV     = 3'd1,
    LOAD_ERR = 3'd2,
    SEND     = 3'd3,
    WAIT     = 3'd4
  } state_e;

  localparam logic [7:0] CH_H     = 8'h48;
  localparam logic [7:0] CH_T     = 8'h54;
  localparam logic [7:0] CH_COLON = 8'h3A;
  localparam logic [7:0] CH_SPACE = 8'h20;
  localparam logic [7:0] CH_E     = 8'h45;
  localparam logic [7:0] CH_R     = 8'h52;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] ASCII_0  = 8'h30;

  localparam int FRAME_LEN_OK  = 13;
  localparam int FRAME_LEN_ERR = 5;

  // Double-dabble correction: a BCD nibble of 5 or more would overflow past 9 once doubled.
  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - 8-bit sequential double-dabble binary to 3-digit BCD converter
//
// Ports:
//   clk_i   : clock
//   rst_ni  : asynchronous active-low reset
//   start_i : one-cycle pulse, loads bin_i and begins an 8-cycle conversion
//   bin_i   : binary value 0..255
//   bcd_o   : {hundreds, tens, ones}, valid from the cycle after done_o
//   done_o  : high in the cycle whose closing edge performs the final shift
module bin2bcd_seq
  import dht11_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic [7:0]  bin_i,
  output logic [11:0] bcd_o,
  output logic        done_o
);

  logic [7:0]  sh_q;
  logic [11:0] bcd_q;
  logic [2:0]  cnt_q;
  logic        run_q;
  logic [11:0] adj;

  assign adj = {add3(bcd_q[11:8]), add3(bcd_q[7:4]), add3(bcd_q[3:0])};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sh_q  <= 8'h00;
      bcd_q <= 12'h000;
      cnt_q <= 3'd0;
      run_q <= 1'b0;
    end else if (start_i) begin
      sh_q  <= bin_i;
      bcd_q <= 12'h000;
      cnt_q <= 3'd0;
      run_q <= 1'b1;
    end else if (run_q) begin
      // Hundreds digit never exceeds 2 for 8-bit input, so the top adjusted bit is always dropped safely.
      {bcd_q, sh_q} <= {adj[10:0], sh_q, 1'b0};
      cnt_q         <= cnt_q + 3'd1;
      if (cnt_q == 3'd7) begin
        run_q <= 1'b0;
      end
    end
  end

  // Signalled one cycle early so the caller can leave its wait state on the edge that finishes the result.
  assign done_o = run_q && (cnt_q == 3'd7);
  assign bcd_o  = bcd_q;

endmodule

// File: rtl/dht11_uart_reporter.sv
// rtl/dht11_uart_reporter.sv - formats DHT11 measurements as ASCII text frames for a UART transmitter
//
// Ports:
//   clk         : clock
//   rst         : asynchronous active-low reset
//   dht11_done  : one-cycle pulse, measurement finished
//   dht11_valid : checksum OK, sampled with dht11_done
//   rh_data     : humidity integer byte, sampled with dht11_done
//   t_data      : temperature integer byte, sampled with dht11_done
//   tx_busy     : UART transmitter busy
//   tx_done     : one-cycle pulse, UART finished the current byte
//   tx_start    : one-cycle request to send tx_data
//   tx_data     : byte to send, held from tx_start until tx_done
//   busy        : frame conversion or transmission in progress
//   drop        : one-cycle pulse, a measurement arrived while busy and was discarded
module dht11_uart_reporter
  import dht11_pkg::*;
#(
  parameter logic SEND_ERR = 1'b1,
  parameter logic EOL_CRLF = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       dht11_done,
  input  logic       dht11_valid,
  input  logic [7:0] rh_data,
  input  logic [7:0] t_data,
  input  logic       tx_busy,
  input  logic       tx_done,
  output logic       tx_start,
  output logic [7:0] tx_data,
  output logic       busy,
  output logic       drop
);

  localparam int LEN_OK  = EOL_CRLF ? FRAME_LEN_OK  : FRAME_LEN_OK - 1;
  localparam int LEN_ERR = EOL_CRLF ? FRAME_LEN_ERR : FRAME_LEN_ERR - 1;
  localparam logic [3:0] LAST_OK  = 4'(LEN_OK - 1);
  localparam logic [3:0] LAST_ERR = 4'(LEN_ERR - 1);
  localparam logic [7:0] EOL_FIRST = EOL_CRLF ? CH_CR : CH_LF;

  state_e      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic        valid_q, valid_d;
  logic        tx_start_q, tx_start_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        drop_q, drop_d;

  logic        conv_start;
  logic        rh_done, t_done;
  logic [11:0] rh_bcd, t_bcd;
  logic [7:0]  frame_byte;
  logic [3:0]  last_idx;

  // The converters capture rh_data/t_data themselves on conv_start.
  bin2bcd_seq u_rh_bcd (
    .clk_i   (clk),
    .rst_ni  (rst),
    .start_i (conv_start),
    .bin_i   (rh_data),
    .bcd_o   (rh_bcd),
    .done_o  (rh_done)
  );

  bin2bcd_seq u_t_bcd (
    .clk_i   (clk),
    .rst_ni  (rst),
    .start_i (conv_start),
    .bin_i   (t_data),
    .bcd_o   (t_bcd),
    .done_o  (t_done)
  );

  assign last_idx = valid_q ? LAST_OK : LAST_ERR;

  always_comb begin
    frame_byte = CH_LF;
    if (valid_q) begin
      case (idx_q)
        4'd0:    frame_byte = CH_H;
        4'd1:    frame_byte = CH_COLON;
        4'd2:    frame_byte = ASCII_0 + {4'h0, rh_bcd[11:8]};
        4'd3:    frame_byte = ASCII_0 + {4'h0, rh_bcd[7:4]};
        4'd4:    frame_byte = ASCII_0 + {4'h0, rh_bcd[3:0]};
        4'd5:    frame_byte = CH_SPACE;
        4'd6:    frame_byte = CH_T;
        4'd7:    frame_byte = CH_COLON;
        4'd8:    frame_byte = ASCII_0 + {4'h0, t_bcd[11:8]};
        4'd9:    frame_byte = ASCII_0 + {4'h0, t_bcd[7:4]};
        4'd10:   frame_byte = ASCII_0 + {4'h0, t_bcd[3:0]};
        4'd11:   frame_byte = EOL_FIRST;
        default: frame_byte = CH_LF;
      endcase
    end else begin
      case (idx_q)
        4'd0:    frame_byte = CH_E;
        4'd1:    frame_byte = CH_R;
        4'd2:    frame_byte = CH_R;
        4'd3:    frame_byte = EOL_FIRST;
        default: frame_byte = CH_LF;
      endcase
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    valid_d    = valid_q;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    conv_start = 1'b0;
    // Includes the edge on which WAIT returns to IDLE: that measurement is dropped too.
    drop_d     = dht11_done && (state_q != IDLE);

    case (state_q)
      IDLE: begin
        if (dht11_done) begin
          valid_d = dht11_valid;
          idx_d   = 4'd0;
          if (dht11_valid) begin
            state_d    = CONV;
            conv_start = 1'b1;
          end else if (SEND_ERR) begin
            state_d = LOAD_ERR;
          end
        end
      end
      CONV: begin
        if (rh_done && t_done) begin
          state_d = SEND;
        end
      end
      LOAD_ERR: begin
        state_d = SEND;
      end
      SEND: begin
        if (!tx_busy) begin
          tx_start_d = 1'b1;
          tx_data_d  = frame_byte;
          state_d    = WAIT;
        end
      end
      WAIT: begin
        if (tx_done) begin
          if (idx_q == last_idx) begin
            state_d = IDLE;
          end else begin
            idx_d   = idx_q + 4'd1;
            state_d = SEND;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      idx_q      <= 4'd0;
      valid_q    <= 1'b0;
      tx_start_q <= 1'b0;
      tx_data_q  <= 8'h00;
      drop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      valid_q    <= valid_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      drop_q     <= drop_d;
    end
  end

  assign tx_start = tx_start_q;
  assign tx_data  = tx_data_q;
  assign busy     = (state_q != IDLE);
  assign drop     = drop_q;

endmodule

// File: tb/tb_dht11_uart_reporter.sv
// tb/tb_dht11_uart_reporter.sv - scoreboard bench for dht11_uart_reporter, two parameter sets side by side
module tb_dht11_uart_reporter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       dht11_done = 1'b0;
  logic       dht11_valid = 1'b0;
  logic [7:0] rh_data = 8'h00;
  logic [7:0] t_data = 8'h00;
  logic       tx_busy = 1'b0;

  logic [1:0] tx_done_w = 2'b00;
  logic [1:0] tx_start_w;
  logic [1:0] busy_w;
  logic [1:0] drop_w;
  logic [7:0] tx_data_w [2];

  logic [7:0] exp_q [2][$];
  int         start_cnt [2] = '{0, 0};
  int         drop_cnt [2] = '{0, 0};
  int         uart_cnt [2] = '{0, 0};
  logic       inflight [2] = '{1'b0, 1'b0};
  logic [7:0] held [2];

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  // u0: ERR frames on, CR LF line end. u1: invalid measurements discarded, LF only.
  dht11_uart_reporter #(.SEND_ERR(1'b1), .EOL_CRLF(1'b1)) u0 (
    .clk(clk), .rst(rst), .dht11_done(dht11_done), .dht11_valid(dht11_valid),
    .rh_data(rh_data), .t_data(t_data), .tx_busy(tx_busy), .tx_done(tx_done_w[0]),
    .tx_start(tx_start_w[0]), .tx_data(tx_data_w[0]), .busy(busy_w[0]), .drop(drop_w[0])
  );

  dht11_uart_reporter #(.SEND_ERR(1'b0), .EOL_CRLF(1'b0)) u1 (
    .clk(clk), .rst(rst), .dht11_done(dht11_done), .dht11_valid(dht11_valid),
    .rh_data(rh_data), .t_data(t_data), .tx_busy(tx_busy), .tx_done(tx_done_w[1]),
    .tx_start(tx_start_w[1]), .tx_data(tx_data_w[1]), .busy(busy_w[1]), .drop(drop_w[1])
  );

  task automatic check(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Monitor and UART model share one process so tx_done is read before it is updated.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst) begin
        inflight[i] = 1'b0;
      end else begin
        if (tx_done_w[i] && inflight[i]) begin
          check($sformatf("u%0d tx_data hold", i), int'(tx_data_w[i]), int'(held[i]));
          inflight[i] = 1'b0;
        end
        if (tx_start_w[i]) begin
          start_cnt[i]++;
          check($sformatf("u%0d byte expected", i), int'(exp_q[i].size() != 0), 1);
          if (exp_q[i].size() != 0) begin
            check($sformatf("u%0d byte %0d", i, start_cnt[i]), int'(tx_data_w[i]), int'(exp_q[i].pop_front()));
          end
          held[i]     = tx_data_w[i];
          inflight[i] = 1'b1;
        end
        if (drop_w[i]) drop_cnt[i]++;
      end
      tx_done_w[i] = 1'b0;
      if (uart_cnt[i] > 0) begin
        uart_cnt[i]--;
        if (uart_cnt[i] == 0) tx_done_w[i] = 1'b1;
      end
      if (tx_start_w[i]) uart_cnt[i] = 3;
    end
  end

  task automatic push_ok(input string body);
    for (int k = 0; k < body.len(); k++) begin
      exp_q[0].push_back(body[k]);
      exp_q[1].push_back(body[k]);
    end
    exp_q[0].push_back(8'h0D);
    exp_q[0].push_back(8'h0A);
    exp_q[1].push_back(8'h0A);
  endtask

  task automatic push_err();
    exp_q[0].push_back(8'h45);
    exp_q[0].push_back(8'h52);
    exp_q[0].push_back(8'h52);
    exp_q[0].push_back(8'h0D);
    exp_q[0].push_back(8'h0A);
  endtask

  task automatic measure(input logic [7:0] rh, input logic [7:0] t, input logic v);
    @(negedge clk);
    dht11_done  = 1'b1;
    dht11_valid = v;
    rh_data     = rh;
    t_data      = t;
    @(negedge clk);
    dht11_done  = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy_w != 2'b00 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check({name, " idle"}, int'(busy_w), 0);
    check({name, " u0 queue drained"}, exp_q[0].size(), 0);
    check({name, " u1 queue drained"}, exp_q[1].size(), 0);
  endtask

  task automatic wait_starts(input int target);
    int n = 0;
    while (start_cnt[0] < target && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("reach byte", start_cnt[0], target);
  endtask

  initial begin
    int base0, base1, lat;

    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("u%0d reset tx_start", i), int'(tx_start_w[i]), 0);
      check($sformatf("u%0d reset tx_data", i), int'(tx_data_w[i]), 0);
      check($sformatf("u%0d reset busy", i), int'(busy_w[i]), 0);
      check($sformatf("u%0d reset drop", i), int'(drop_w[i]), 0);
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // 1: typical frame and latency from dht11_done to first tx_start
    base0 = start_cnt[0]; base1 = start_cnt[1];
    push_ok("H:045 T:023");
    measure(8'd45, 8'd23, 1'b1);
    check("busy after done", int'(busy_w), 3);
    lat = 0;
    while (!tx_start_w[0] && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    check("first tx_start latency", lat, 9);
    wait_idle("t1");
    check("t1 u0 tx_start count", start_cnt[0] - base0, 13);
    check("t1 u1 tx_start count", start_cnt[1] - base1, 12);

    // 2: range ends of the converter, plus leading zeros
    push_ok("H:255 T:000");
    measure(8'd255, 8'd0, 1'b1);
    wait_idle("t2a");
    push_ok("H:007 T:199");
    measure(8'd7, 8'd199, 1'b1);
    wait_idle("t2b");

    // 3: checksum failure
    base0 = start_cnt[0]; base1 = start_cnt[1];
    push_err();
    measure(8'd45, 8'd23, 1'b0);
    check("t3 u0 busy on err", int'(busy_w[0]), 1);
    check("t3 u1 busy on err", int'(busy_w[1]), 0);
    wait_idle("t3");
    check("t3 u0 tx_start count", start_cnt[0] - base0, 5);
    check("t3 u1 tx_start count", start_cnt[1] - base1, 0);

    // 4: measurement arriving mid-frame is dropped
    base0 = start_cnt[0]; base1 = start_cnt[1];
    push_ok("H:060 T:021");
    measure(8'd60, 8'd21, 1'b1);
    wait_starts(base0 + 6);
    measure(8'd99, 8'd98, 1'b1);
    wait_idle("t4");
    repeat (30) @(negedge clk);
    check("t4 u0 drop count", drop_cnt[0], 1);
    check("t4 u1 drop count", drop_cnt[1], 1);
    check("t4 u0 no second frame", start_cnt[0] - base0, 13);
    check("t4 u1 no second frame", start_cnt[1] - base1, 12);
    check("t4 busy after", int'(busy_w), 0);

    // 5: tx_busy withholds the first byte
    base0 = start_cnt[0];
    tx_busy = 1'b1;
    push_ok("H:100 T:050");
    measure(8'd100, 8'd50, 1'b1);
    repeat (20) @(negedge clk);
    check("t5 tx_start withheld", start_cnt[0] - base0, 0);
    check("t5 busy while waiting", int'(busy_w), 3);
    tx_busy = 1'b0;
    wait_idle("t5");

    // 6: reset in the middle of byte 7
    base0 = start_cnt[0];
    push_ok("H:045 T:023");
    measure(8'd45, 8'd23, 1'b1);
    wait_starts(base0 + 8);
    #2;
    rst = 1'b0;
    #1;
    check("t6 reset tx_start", int'(tx_start_w), 0);
    check("t6 reset busy", int'(busy_w), 0);
    check("t6 reset drop", int'(drop_w), 0);
    check("t6 u0 reset tx_data", int'(tx_data_w[0]), 0);
    check("t6 u1 reset tx_data", int'(tx_data_w[1]), 0);
    exp_q[0].delete();
    exp_q[1].delete();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (10) @(negedge clk);
    base0 = start_cnt[0];
    check("t6 nothing after reset", start_cnt[0] - base0, 0);
    push_ok("H:012 T:034");
    measure(8'd12, 8'd34, 1'b1);
    wait_idle("t6");
    check("t6 u0 tx_start count", start_cnt[0] - base0, 13);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
